demux1x4_tdm: RTL and testbench
===============================

# demux1x4_tdm

Time-division 1-to-4 demultiplexer: the receive end of a 4-slot serial lane produced by the 4:1 mux path. It accepts one data beat per slot on a single input, tracks slot position with a 2-bit counter locked to a start-of-frame marker, and presents each complete frame as four registered, parallel outputs with a one-cycle frame strobe. It sits downstream of the mux and restores the four original channels.

## Interface
- WIDTH, 1, data width of each lane and of the serial input
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  WIDTH  serial slot data
- din_valid  input  1  din carries a beat this cycle; low means stall
- sof  input  1  start of frame; qualified by din_valid; marks the slot-0 beat
- y0  output  WIDTH  demultiplexed lane 0 (slot 0), registered
- y1  output  WIDTH  demultiplexed lane 1 (slot 1), registered
- y2  output  WIDTH  demultiplexed lane 2 (slot 2), registered
- y3  output  WIDTH  demultiplexed lane 3 (slot 3), registered
- frame_valid  output  1  one-cycle pulse when y0..y3 update
- sel  output  2  current slot counter, the slot the next accepted beat fills
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on a framing violation
- frame_cnt  output  8  count of completed frames, wraps 255 -> 0

## Operation
- A beat is accepted only when din_valid=1. With din_valid=0, no register changes except that frame_valid and sync_err drop to 0.
- Shadow registers s0..s2 (WIDTH each) hold partial-frame data. y0..y3 change only on frame completion.
- State HUNT (reset state): sel=0. Beats without sof are discarded. A beat with sof writes s0<=din, sel<=1, state<=LOCKED.
- State LOCKED, beat with sof=0:
  - sel=1 or 2: s[sel]<=din, sel<=sel+1.
  - sel=3: y0<=s0, y1<=s1, y2<=s2, y3<=din, frame_valid<=1, frame_cnt<=frame_cnt+1 (mod 256), sel<=0. Stays LOCKED.
  - sel=0 (sof missing): sync_err<=1, beat discarded, state<=HUNT, sel stays 0.
- State LOCKED, beat with sof=1:
  - sel=0: normal slot-0 beat, s0<=din, sel<=1.
  - sel=1..3 (early sof): sync_err<=1, partial frame dropped, beat taken as new slot 0: s0<=din, sel<=1, stays LOCKED. y0..y3 and frame_cnt unchanged.
- sof with din_valid=0 is ignored.
- Incomplete frames never reach y0..y3. Outputs hold the last complete frame indefinitely.

## Timing
- All state updates on rising clk. Outputs are registered with no combinational path from inputs.
- Latency: the slot-3 beat sampled at edge N makes y0..y3 and frame_valid visible after edge N. frame_valid is high for exactly that one cycle, with no pulse if the next cycle also completes a frame only after four further beats.
- Minimum frame period: 4 cycles, with back-to-back frames at full rate allowed. frame_valid can then pulse every 4th cycle.
- sync_err is high for one cycle, the cycle after the offending edge.
- Reset (rst=1 at an edge, including mid-frame): y0..y3=0, s0..s2=0, sel=0, frame_valid=0, sync_err=0, frame_cnt=0, locked=0, state HUNT. rst overrides all beats on that edge.
- locked is high the cycle after the sof beat that leaves HUNT. It drops the cycle after a missing-sof error.

## Test plan
- Reset then frame: rst 2 cycles; beats (sof,din)=(1,1),(0,0),(0,0),(0,1) on consecutive cycles -> after 4th edge y0..y3=1,0,0,1, frame_valid single pulse, frame_cnt=1, sel=0, locked=1.
- Stalls: same frame with din_valid=0 for 3 cycles between slots 1 and 2 -> sel holds at 2 during stall, identical outputs, frame_valid only after slot-3 beat.
- Hunt discard: 5 beats without sof after reset -> locked=0, sel=0, no frame_valid; then a valid frame 0,1,1,0 -> y=0,1,1,0.
- Early sof: lock, send slots 0,1 then sof beat with din=1, then 0,0,1 -> sync_err pulse at 3rd beat, y unchanged until the 6th beat, then y=1,0,0,1, frame_cnt incremented once.
- Missing sof: after one good frame, send beat with sof=0 at sel=0 -> sync_err pulse, locked=0, y holds previous frame.
- Mid-frame reset and wrap: assert rst at sel=2 -> all outputs 0 next cycle; then 256 back-to-back frames -> frame_cnt=0, frame_valid every 4th cycle.

Source files
------------

// File: rtl/demux1x4_tdm.sv
// demux1x4_tdm: receive end of a 4-slot TDM lane.
// Slot beats are collected into shadow registers. A complete frame is then
// presented as four registered lanes, together with a one-cycle frame strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | waiting for a sof beat; beats without sof are discarded
// LOCKED | slot counter aligned to the frame; collecting slot beats
module demux1x4_tdm #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    input  logic             i_sof,
    output logic [WIDTH-1:0] o_y0,
    output logic [WIDTH-1:0] o_y1,
    output logic [WIDTH-1:0] o_y2,
    output logic [WIDTH-1:0] o_y3,
    output logic             o_frame_valid,
    output logic [1:0]       o_sel,
    output logic             o_locked,
    output logic             o_sync_err,
    output logic [7:0]       o_frame_cnt
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t           r_state;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_s0, r_s1, r_s2;
    logic [WIDTH-1:0] r_y0, r_y1, r_y2, r_y3;
    logic             r_frame_valid;
    logic             r_sync_err;
    logic [7:0]       r_frame_cnt;

    state_t           w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic [WIDTH-1:0] w_s0_nxt, w_s1_nxt, w_s2_nxt;
    logic [WIDTH-1:0] w_y0_nxt, w_y1_nxt, w_y2_nxt, w_y3_nxt;
    logic             w_frame_valid_nxt;
    logic             w_sync_err_nxt;
    logic [7:0]       w_frame_cnt_nxt;

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= HUNT;
            r_sel         <= 2'd0;
            r_s0          <= '0;
            r_s1          <= '0;
            r_s2          <= '0;
            r_y0          <= '0;
            r_y1          <= '0;
            r_y2          <= '0;
            r_y3          <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_s0          <= w_s0_nxt;
            r_s1          <= w_s1_nxt;
            r_s2          <= w_s2_nxt;
            r_y0          <= w_y0_nxt;
            r_y1          <= w_y1_nxt;
            r_y2          <= w_y2_nxt;
            r_y3          <= w_y3_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
        end
    end

    // Next-state logic. Everything holds unless a beat is accepted; the two pulses default low.
    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_s0_nxt          = r_s0;
        w_s1_nxt          = r_s1;
        w_s2_nxt          = r_s2;
        w_y0_nxt          = r_y0;
        w_y1_nxt          = r_y1;
        w_y2_nxt          = r_y2;
        w_y3_nxt          = r_y3;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;
        w_frame_cnt_nxt   = r_frame_cnt;

        if (i_din_valid) begin
            if (r_state == HUNT) begin
                if (i_sof) begin
                    w_s0_nxt    = i_din;
                    w_sel_nxt   = 2'd1;
                    w_state_nxt = LOCKED;
                end
            end else if (i_sof) begin
                // An early sof drops the partial frame and resynchronises on this beat.
                if (r_sel != 2'd0) begin
                    w_sync_err_nxt = 1'b1;
                end
                w_s0_nxt  = i_din;
                w_sel_nxt = 2'd1;
            end else begin
                case (r_sel)
                    2'd0: begin
                        // A missing sof means alignment is lost; fall back to hunting.
                        w_sync_err_nxt = 1'b1;
                        w_state_nxt    = HUNT;
                    end
                    2'd1: begin
                        w_s1_nxt  = i_din;
                        w_sel_nxt = 2'd2;
                    end
                    2'd2: begin
                        w_s2_nxt  = i_din;
                        w_sel_nxt = 2'd3;
                    end
                    default: begin
                        w_y0_nxt          = r_s0;
                        w_y1_nxt          = r_s1;
                        w_y2_nxt          = r_s2;
                        w_y3_nxt          = i_din;
                        w_frame_valid_nxt = 1'b1;
                        w_frame_cnt_nxt   = r_frame_cnt + 8'd1;
                        w_sel_nxt         = 2'd0;
                    end
                endcase
            end
        end
    end

    assign o_y0          = r_y0;
    assign o_y1          = r_y1;
    assign o_y2          = r_y2;
    assign o_y3          = r_y3;
    assign o_frame_valid = r_frame_valid;
    assign o_sel         = r_sel;
    assign o_locked      = (r_state == LOCKED);
    assign o_sync_err    = r_sync_err;
    assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_demux1x4_tdm.sv
// tb_demux1x4_tdm: directed vectors with hand-computed expectations for demux1x4_tdm.
module tb_demux1x4_tdm;

    localparam int WIDTH = 8;

    logic             i_clk;
    logic             i_rst;
    logic [WIDTH-1:0] i_din;
    logic             i_din_valid;
    logic             i_sof;
    logic [WIDTH-1:0] o_y0, o_y1, o_y2, o_y3;
    logic             o_frame_valid;
    logic [1:0]       o_sel;
    logic             o_locked;
    logic             o_sync_err;
    logic [7:0]       o_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    demux1x4_tdm #(.WIDTH(WIDTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_din        (i_din),
        .i_din_valid  (i_din_valid),
        .i_sof        (i_sof),
        .o_y0         (o_y0),
        .o_y1         (o_y1),
        .o_y2         (o_y2),
        .o_y3         (o_y3),
        .o_frame_valid(o_frame_valid),
        .o_sel        (o_sel),
        .o_locked     (o_locked),
        .o_sync_err   (o_sync_err),
        .o_frame_cnt  (o_frame_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
        i_din_valid = v;
        i_sof       = s;
        i_din       = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_y(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        chk({tag, ".y0"}, 32'(o_y0), 32'(e0));
        chk({tag, ".y1"}, 32'(o_y1), 32'(e1));
        chk({tag, ".y2"}, 32'(o_y2), 32'(e2));
        chk({tag, ".y3"}, 32'(o_y3), 32'(e3));
    endtask

    initial begin
        i_rst = 1'b1; i_din = '0; i_din_valid = 1'b0; i_sof = 1'b0;

        // Reset, then one frame 1,0,0,1
        step(0, 0, 0);
        step(0, 0, 0);
        chk_y("rst", 0, 0, 0, 0);
        chk("rst.sel", 32'(o_sel), 0);
        chk("rst.locked", 32'(o_locked), 0);
        chk("rst.fv", 32'(o_frame_valid), 0);
        chk("rst.cnt", 32'(o_frame_cnt), 0);
        chk("rst.err", 32'(o_sync_err), 0);
        i_rst = 1'b0;
        step(1, 1, 1);
        chk("f1.locked", 32'(o_locked), 1);
        chk("f1.sel1", 32'(o_sel), 1);
        step(1, 0, 0);
        chk("f1.sel2", 32'(o_sel), 2);
        step(1, 0, 0);
        chk("f1.sel3", 32'(o_sel), 3);
        chk("f1.fv_early", 32'(o_frame_valid), 0);
        chk_y("f1.hold", 0, 0, 0, 0);
        step(1, 0, 1);
        chk_y("f1", 1, 0, 0, 1);
        chk("f1.fv", 32'(o_frame_valid), 1);
        chk("f1.cnt", 32'(o_frame_cnt), 1);
        chk("f1.sel0", 32'(o_sel), 0);
        step(0, 0, 0);
        chk("f1.fv_drop", 32'(o_frame_valid), 0);
        chk_y("f1.idle", 1, 0, 0, 1);

        // Stalls between slots 1 and 2; a sof during a stall is ignored
        step(1, 1, 1);
        step(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, (k == 1), 8'hAA);
            chk("stall.sel", 32'(o_sel), 2);
            chk("stall.fv", 32'(o_frame_valid), 0);
            chk("stall.err", 32'(o_sync_err), 0);
        end
        step(1, 0, 0);
        chk("stall.fv3", 32'(o_frame_valid), 0);
        step(1, 0, 1);
        chk_y("stall", 1, 0, 0, 1);
        chk("stall.fv", 32'(o_frame_valid), 1);
        chk("stall.cnt", 32'(o_frame_cnt), 2);

        // Hunt: beats without sof are discarded
        i_rst = 1'b1;
        step(0, 0, 0);
        i_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 8'(k + 3));
            chk("hunt.locked", 32'(o_locked), 0);
            chk("hunt.sel", 32'(o_sel), 0);
            chk("hunt.fv", 32'(o_frame_valid), 0);
            chk("hunt.err", 32'(o_sync_err), 0);
        end
        step(1, 1, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        chk_y("hunt", 0, 1, 1, 0);
        chk("hunt.cnt", 32'(o_frame_cnt), 1);
        chk("hunt.fv_end", 32'(o_frame_valid), 1);

        // Early sof: partial frame dropped, resync on the sof beat
        step(1, 1, 7);
        step(1, 0, 7);
        step(1, 1, 1);
        chk("early.err", 32'(o_sync_err), 1);
        chk("early.sel", 32'(o_sel), 1);
        chk("early.locked", 32'(o_locked), 1);
        chk_y("early.hold", 0, 1, 1, 0);
        step(1, 0, 0);
        chk("early.err_drop", 32'(o_sync_err), 0);
        step(1, 0, 0);
        chk("early.cnt_hold", 32'(o_frame_cnt), 1);
        step(1, 0, 1);
        chk_y("early", 1, 0, 0, 1);
        chk("early.cnt", 32'(o_frame_cnt), 2);
        chk("early.fv", 32'(o_frame_valid), 1);

        // Missing sof at slot 0
        step(1, 0, 9);
        chk("miss.err", 32'(o_sync_err), 1);
        chk("miss.locked", 32'(o_locked), 0);
        chk("miss.sel", 32'(o_sel), 0);
        chk("miss.fv", 32'(o_frame_valid), 0);
        chk_y("miss.hold", 1, 0, 0, 1);
        step(0, 0, 0);
        chk("miss.err_drop", 32'(o_sync_err), 0);

        // Mid-frame reset, with a beat present on the reset edge
        step(1, 1, 3);
        step(1, 0, 4);
        chk("mid.sel", 32'(o_sel), 2);
        i_rst = 1'b1;
        step(1, 0, 5);
        i_rst = 1'b0;
        chk_y("mid", 0, 0, 0, 0);
        chk("mid.sel0", 32'(o_sel), 0);
        chk("mid.locked", 32'(o_locked), 0);
        chk("mid.cnt", 32'(o_frame_cnt), 0);
        chk("mid.fv", 32'(o_frame_valid), 0);

        // 256 back-to-back frames: frame_valid every 4th cycle, count wraps to 0
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 4; k++) begin
                step(1, (k == 0), 8'((f * 4 + k) & 255));
                chk("wrap.fv", 32'(o_frame_valid), (k == 3) ? 32'd1 : 32'd0);
                if (k == 3) begin
                    chk("wrap.cnt", 32'(o_frame_cnt), 32'((f + 1) & 255));
                end
            end
        end
        chk_y("wrap", 252, 253, 254, 255);
        chk("wrap.cnt0", 32'(o_frame_cnt), 0);
        chk("wrap.locked", 32'(o_locked), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
